// File: rtl/cla_nibble_seq_if.sv
// Start/done handshake, operands and result/flag bus between the ALU control
// path (master) and the nibble-serial add/sub controller (slave).
interface cla_nibble_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_nibble_seq.sv
// WIDTH-bit add/subtract sequenced through one external 4-bit CLA slice,
// one nibble per cycle, LSB first, carry chained through a register.
module cla_nibble_seq #(
    parameter int WIDTH = 32,
    parameter int NIB   = WIDTH / 4
) (
    input  logic                   clk,
    input  logic                   reset,
    cla_nibble_seq_if.slave        bus,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic                   slice_cin,
    input  logic [3:0]             slice_s,
    input  logic                   slice_cout
);
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg,  state_next;
    logic [IDXW-1:0]  idx_reg,    idx_next;
    logic             carry_reg,  carry_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] beff_reg,   beff_next;
    logic [WIDTH-1:0] sum_reg,    sum_next;
    logic             cout_reg,   cout_next;
    logic             ovf_reg,    ovf_next;
    logic             zero_reg,   zero_next;

    // Nibble views of the latched operands, selected by idx during RUN.
    logic [3:0] a_nib    [NIB];
    logic [3:0] beff_nib [NIB];

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi]    = a_reg[4*gi +: 4];
            assign beff_nib[gi] = beff_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            beff_reg  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            a_reg     <= a_next;
            beff_reg  <= beff_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
            zero_reg  <= zero_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        a_next     = a_reg;
        beff_next  = beff_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        zero_next  = zero_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_next     = bus.a;
                    beff_next  = bus.sub ? ~bus.b : bus.b;
                    carry_next = bus.sub;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                sum_next[{idx_reg, 2'b00} +: 4] = slice_s;
                carry_next = slice_cout;
                if (idx_reg == LAST_IDX) begin
                    // Flags see the fully assembled sum, last nibble included.
                    cout_next  = slice_cout;
                    zero_next  = (sum_next == '0);
                    ovf_next   = (a_reg[WIDTH-1] == beff_reg[WIDTH-1]) &&
                                 (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        slice_a   = 4'd0;
        slice_b   = 4'd0;
        slice_cin = 1'b0;
        if (state_reg == RUN) begin
            slice_a   = a_nib[idx_reg];
            slice_b   = beff_nib[idx_reg];
            slice_cin = carry_reg;
        end
    end

    assign bus.ready = (state_reg == IDLE);
    assign bus.busy  = (state_reg == RUN);
    assign bus.done  = (state_reg == DONE);
    assign bus.sum   = sum_reg;
    assign bus.cout  = cout_reg;
    assign bus.ovf   = ovf_reg;
    assign bus.zero  = zero_reg;
endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq: behavioural 4-bit slice, vector table plus
// hand-written handshake/reset sequences, results checked via a scoreboard.
module tb_cla_nibble_seq;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } op_t;

    logic clk;
    logic reset;
    logic [3:0] slice_a, slice_b, slice_s;
    logic slice_cin, slice_cout;

    cla_nibble_seq_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_s   (slice_s),
        .slice_cout(slice_cout)
    );

    // Behavioural stand-in for the external cla4 slice.
    assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    op_t  exp_q[$];
    logic [7:0] cin_log;

    function automatic op_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s);
        op_t r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, s};
        r.a    = a;
        r.b    = b;
        r.sub  = s;
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        r.zero = (full[WIDTH-1:0] == '0);
        return r;
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 sum=%h, required no done", bus.sum);
            end else begin
                op_t e;
                e = exp_q.pop_front();
                $display("op a=%h b=%h sub=%0b -> sum=%h cout=%0b ovf=%0b zero=%0b",
                         e.a, e.b, e.sub, bus.sum, bus.cout, bus.ovf, bus.zero);
                if (bus.sum !== e.sum || bus.cout !== e.cout ||
                    bus.ovf !== e.ovf || bus.zero !== e.zero) begin
                    errors++;
                    $display("FAIL result: got sum=%h cout=%0b ovf=%0b zero=%0b, required sum=%h cout=%0b ovf=%0b zero=%0b",
                             bus.sum, bus.cout, bus.ovf, bus.zero, e.sum, e.cout, e.ovf, e.zero);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    // Returns cycles from the accepting edge until done is seen (-1 on timeout);
    // call right after the negedge following the accepting edge.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy && c < 8) cin_log[c] = slice_cin;
            if (bus.done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic check_latency(input int cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL latency: done after %0d cycles, required 8", cyc);
        end
    endtask

    task automatic wait_ready;
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("ready_wait", bus.ready, 1'b1);
    endtask

    task automatic run_op(input op_t op);
        int cyc;
        wait_ready();
        bus.start = 1'b1;
        bus.a     = op.a;
        bus.b     = op.b;
        bus.sub   = op.sub;
        exp_q.push_back(op);
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        cin_log    = '0;
        cin_log[0] = slice_cin;
        wait_done(cyc);
        check_latency(cyc);
        @(negedge clk);
        check_bit("ready_after_done", bus.ready, 1'b1);
        check_bit("done_one_cycle", bus.done, 1'b0);
    endtask

    op_t vec[6];

    initial begin
        int cyc;
        vec[0] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vec[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vec[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vec[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vec[4] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vec[5] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_bit("rst_ready", bus.ready, 1'b1);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);
        check_bit("rst_sum_zero", (bus.sum == '0), 1'b1);
        check_bit("rst_flags", bus.cout | bus.ovf | bus.zero, 1'b0);
        check_bit("rst_slice", |{slice_a, slice_b, slice_cin}, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op(vec[i]);
            if (i == 1) begin
                checks++;
                if (cin_log !== 8'hFE) begin
                    errors++;
                    $display("FAIL ripple_cin: slice_cin per nibble=%b, required 11111110", cin_log);
                end
            end
        end

        for (int i = 0; i < 6; i++) begin
            run_op(model($urandom, $urandom, 1'($urandom_range(0, 1))));
        end

        // start held high for a whole operation with operands churning.
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        bus.sub   = 1'b0;
        exp_q.push_back(model(32'd3, 32'd4, 1'b0));
        cyc = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.done) begin
                bus.start = 1'b0;
                cyc = n;
                break;
            end
            bus.a   = $urandom;
            bus.b   = $urandom;
            bus.sub = 1'($urandom_range(0, 1));
        end
        check_latency(cyc);
        repeat (12) @(negedge clk);

        // start asserted in the done cycle is only accepted one cycle later.
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd20;
        bus.sub   = 1'b0;
        exp_q.push_back(model(32'd10, 32'd20, 1'b0));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        check_latency(cyc);
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd1;
        exp_q.push_back(model(32'd100, 32'd1, 1'b0));
        @(negedge clk);
        check_bit("done_start_ignored_ready", bus.ready, 1'b1);
        check_bit("done_start_ignored_busy", bus.busy, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check_bit("accept_after_done", bus.busy, 1'b1);
        wait_done(cyc);
        check_latency(cyc);

        // Reset during the 4th RUN cycle aborts with no done.
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 32'h11111111;
        bus.b     = 32'h22222222;
        bus.sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_bit("abort_ready", bus.ready, 1'b1);
        check_bit("abort_busy", bus.busy, 1'b0);
        check_bit("abort_done", bus.done, 1'b0);
        check_bit("abort_sum_zero", (bus.sum == '0), 1'b1);
        check_bit("abort_slice", |{slice_a, slice_b, slice_cin}, 1'b0);
        repeat (15) @(negedge clk);
        run_op(model(32'd3, 32'd4, 1'b0));

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: %0d outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
